// File: rtl/mem_stage_pkg.sv
// Shared types and helpers for the memory-access stage.
package mem_stage_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } mem_size_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_e;

    // Size 2'b11 falls through to a full word.
    function automatic logic [3:0] byte_en(logic [1:0] size, logic [1:0] off);
        case (size)
            SZ_BYTE: byte_en = 4'b0001 << off;
            SZ_HALF: byte_en = 4'b0011 << {off[1], 1'b0};
            default: byte_en = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory bus: single-port req/ack handshake, read data valid with ack.
interface mem_stage_if;
    import mem_stage_pkg::*;

    logic            dmem_req;
    logic            dmem_we;
    logic [XLEN-1:0] dmem_addr;
    logic [XLEN-1:0] dmem_wdata;
    logic [3:0]      dmem_be;
    logic            dmem_ack;
    logic [XLEN-1:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        output dmem_ack, dmem_rdata
    );

endinterface

// File: rtl/mem_stage_load_align.sv
// Combinational load lane select and sign/zero extension; reusable by a later cache.
module load_align
    import mem_stage_pkg::*;
(
    input  logic [XLEN-1:0] rdata_i,
    input  logic [1:0]      addr_i,
    input  logic [1:0]      size_i,
    input  logic            unsigned_i,
    output logic [XLEN-1:0] data_o
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b = rdata_i[{addr_i, 3'b000} +: 8];
        lane_h = rdata_i[{addr_i[1], 4'b0000} +: 16];
        case (size_i)
            SZ_BYTE: data_o = {{24{~unsigned_i & lane_b[7]}}, lane_b};
            SZ_HALF: data_o = {{16{~unsigned_i & lane_h[15]}}, lane_h};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: registers execute results, runs one dmem transaction, emits writeback.
// Optional misaligned-access trap under macro MEM_MISALIGN_TRAP_EN.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [XLEN-1:0] alu_res_i,
    input  logic [XLEN-1:0] b_res_i,
    input  logic [XLEN-1:0] pc_res_i,
    input  logic [4:0]      rd_i,
    input  logic            reg_write_i,
    input  logic            mem_read_i,
    input  logic            mem_write_i,
    input  logic [1:0]      mem_size_i,
    input  logic            mem_unsigned_i,
    mem_stage_if.master     dmem,
    output logic            wb_valid_o,
    output logic            wb_we_o,
    output logic [4:0]      wb_rd_o,
    output logic [XLEN-1:0] wb_data_o,
    output logic [XLEN-1:0] wb_pc_o
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    output logic            misalign_o
`endif
);

    state_e          state_q;
    logic [XLEN-1:0] addr_q, sdata_q, pc_q;
    logic [4:0]      rd_q;
    logic [1:0]      size_q;
    logic            reg_write_q, load_q, store_q, unsigned_q;
    logic            wb_valid_q, wb_we_q;
    logic [4:0]      wb_rd_q;
    logic [XLEN-1:0] wb_data_q, wb_pc_q;
    logic            misalign_q;

    logic            is_mem, mis, busy;
    logic [XLEN-1:0] load_data;

    assign is_mem = mem_read_i | mem_write_i;
    assign busy   = (state_q == S_BUSY);

`ifdef MEM_MISALIGN_TRAP_EN
    assign mis = is_mem && (((mem_size_i == SZ_HALF) && alu_res_i[0]) ||
                            (mem_size_i[1] && (alu_res_i[1:0] != 2'b00)));
    assign misalign_o = misalign_q;
`else
    assign mis = 1'b0;
`endif

    load_align u_load_align (
        .rdata_i   (dmem.dmem_rdata),
        .addr_i    (addr_q[1:0]),
        .size_i    (size_q),
        .unsigned_i(unsigned_q),
        .data_o    (load_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            sdata_q     <= '0;
            pc_q        <= '0;
            rd_q        <= '0;
            size_q      <= '0;
            reg_write_q <= 1'b0;
            load_q      <= 1'b0;
            store_q     <= 1'b0;
            unsigned_q  <= 1'b0;
            wb_valid_q  <= 1'b0;
            wb_we_q     <= 1'b0;
            wb_rd_q     <= '0;
            wb_data_q   <= '0;
            wb_pc_q     <= '0;
            misalign_q  <= 1'b0;
        end else begin
            wb_valid_q <= 1'b0;
            misalign_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (in_valid_i) begin
                        addr_q      <= alu_res_i;
                        sdata_q     <= b_res_i;
                        pc_q        <= pc_res_i;
                        rd_q        <= rd_i;
                        size_q      <= mem_size_i;
                        reg_write_q <= reg_write_i;
                        load_q      <= mem_read_i;
                        store_q     <= mem_write_i & ~mem_read_i;
                        unsigned_q  <= mem_unsigned_i;
                        if (is_mem && !mis) begin
                            state_q <= S_BUSY;
                        end else begin
                            // Plain ALU result, or a trapped access reporting its address.
                            wb_valid_q <= 1'b1;
                            wb_we_q    <= reg_write_i & ~mis;
                            wb_rd_q    <= rd_i;
                            wb_pc_q    <= pc_res_i;
                            wb_data_q  <= alu_res_i;
                            misalign_q <= mis;
                        end
                    end
                end
                S_BUSY: begin
                    if (dmem.dmem_ack) begin
                        state_q    <= S_IDLE;
                        wb_valid_q <= 1'b1;
                        wb_we_q    <= load_q & reg_write_q;
                        wb_rd_q    <= rd_q;
                        wb_pc_q    <= pc_q;
                        wb_data_q  <= load_q ? load_data : addr_q;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Bus fields come straight from the stage register, so they hold until ack.
    always_comb begin
        dmem.dmem_req   = busy;
        dmem.dmem_we    = busy & store_q;
        dmem.dmem_addr  = {addr_q[XLEN-1:2], 2'b00};
        dmem.dmem_be    = busy ? byte_en(size_q, addr_q[1:0]) : 4'b0000;
        case (size_q)
            SZ_BYTE: dmem.dmem_wdata = {4{sdata_q[7:0]}};
            SZ_HALF: dmem.dmem_wdata = {2{sdata_q[15:0]}};
            default: dmem.dmem_wdata = sdata_q;
        endcase
    end

    assign in_ready_o = ~busy;
    assign wb_valid_o = wb_valid_q;
    assign wb_we_o    = wb_we_q;
    assign wb_rd_o    = wb_rd_q;
    assign wb_data_o  = wb_data_q;
    assign wb_pc_o    = wb_pc_q;

endmodule
